// File: rtl/bus_rr_arbiter_pkg.sv
// Shared bus arbiter definitions: owner width, master indices, FSM encodings.
// Also provides the round-robin pick helper used by bus_rr_arbiter.
package bus_rr_arbiter_pkg;

    localparam int BUS_OWNER_BUS = 2;

    typedef logic [BUS_OWNER_BUS-1:0] owner_t;

    localparam owner_t BUS_OWNER_M0 = 2'd0;
    localparam owner_t BUS_OWNER_M1 = 2'd1;
    localparam owner_t BUS_OWNER_M2 = 2'd2;
    localparam owner_t BUS_OWNER_M3 = 2'd3;

    localparam int ARB_STATE_BUS = 2;

    typedef enum logic [ARB_STATE_BUS-1:0] {
        ARB_IDLE  = 2'd0,
        ARB_OWNED = 2'd1,
        ARB_LOCK  = 2'd2
    } arb_state_t;

    localparam int BUS_TIMEOUT_DEFAULT = 255;

    // Returns {found, index}; the scan is own+1, own+2, own+3, own.
    function automatic logic [2:0] rr_pick(
        input owner_t     own,
        input logic [3:0] req_n
    );
        logic [2:0] r;
        owner_t     idx;
        r = {1'b0, own};
        for (int k = 4; k >= 1; k--) begin
            idx = own + owner_t'(k);
            if (!req_n[idx]) r = {1'b1, idx};
        end
        return r;
    endfunction

endpackage

// File: rtl/bus_arb_watchdog.sv
// Slave-response watchdog: counts strobe-low/ready-high cycles and
// pulses a forced ready plus a timeout flag when the budget is spent.
module bus_arb_watchdog
    import bus_rr_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = BUS_TIMEOUT_DEFAULT,
    parameter int TO_CNT_W       = 8
) (
    input  logic   clk,
    input  logic   reset_,
    input  logic   as_n,
    input  logic   rdy_n,
    input  logic   gnt_chg,
    input  owner_t owner,
    output logic   force_rdy_n,
    output logic   to_err,
    output owner_t to_owner
);

    localparam logic [TO_CNT_W-1:0] LAST = TO_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [TO_CNT_W-1:0] cnt;
    logic                waiting;
    logic                fire;

    assign waiting = !as_n && rdy_n;
    // A ready or a grant change in the expiry cycle suppresses the timeout.
    assign fire    = waiting && (cnt == LAST) && !gnt_chg;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            cnt         <= '0;
            force_rdy_n <= 1'b1;
            to_err      <= 1'b0;
            to_owner    <= BUS_OWNER_M0;
        end else begin
            force_rdy_n <= !fire;
            to_err      <= fire;
            if (fire) to_owner <= owner;
            if (fire || !waiting || gnt_chg) cnt <= '0;
            else cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin bus arbiter with transaction lock for 4 masters.
// Define BUS_ARB_TIMEOUT_EN to add the slave-response watchdog.
module bus_rr_arbiter
    import bus_rr_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = BUS_TIMEOUT_DEFAULT,
    parameter int TO_CNT_W       = 8
) (
    input  logic       clk,
    input  logic       reset_,
    input  logic       m0Req_,
    input  logic       m1Req_,
    input  logic       m2Req_,
    input  logic       m3Req_,
    output logic       m0Grnt_,
    output logic       m1Grnt_,
    output logic       m2Grnt_,
    output logic       m3Grnt_,
    output logic [1:0] owner,
    input  logic       sAs_,
    input  logic       mRdy_,
    output logic       forceRdy_,
    output logic       toErr,
    output logic [1:0] toOwner
);

    arb_state_t state_q, state_d;
    owner_t     owner_q, owner_d;
    logic [3:0] gnt_q, gnt_d;
    logic [3:0] req_n;
    logic [2:0] pick;
    logic       gnt_chg;

    assign req_n   = {m3Req_, m2Req_, m1Req_, m0Req_};
    assign pick    = rr_pick(owner_q, req_n);
    assign gnt_chg = (owner_d != owner_q);

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q <= ARB_IDLE;
            owner_q <= BUS_OWNER_M0;
            gnt_q   <= 4'b1110;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            gnt_q   <= gnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (pick[2]) begin
                    owner_d = pick[1:0];
                    state_d = ARB_OWNED;
                end
            end
            ARB_OWNED: begin
                if (req_n[owner_q]) begin
                    if (sAs_ || !mRdy_) begin
                        owner_d = pick[1:0];
                        state_d = pick[2] ? ARB_OWNED : ARB_IDLE;
                    end else begin
                        state_d = ARB_LOCK;
                    end
                end
            end
            ARB_LOCK: begin
                if (!mRdy_ || !forceRdy_) begin
                    owner_d = pick[1:0];
                    state_d = pick[2] ? ARB_OWNED : ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_comb begin
        gnt_d          = 4'b1111;
        gnt_d[owner_d] = 1'b0;
    end

    assign owner   = owner_q;
    assign m0Grnt_ = gnt_q[0];
    assign m1Grnt_ = gnt_q[1];
    assign m2Grnt_ = gnt_q[2];
    assign m3Grnt_ = gnt_q[3];

`ifdef BUS_ARB_TIMEOUT_EN
    bus_arb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TO_CNT_W       (TO_CNT_W)
    ) u_wdog (
        .clk         (clk),
        .reset_      (reset_),
        .as_n        (sAs_),
        .rdy_n       (mRdy_),
        .gnt_chg     (gnt_chg),
        .owner       (owner_q),
        .force_rdy_n (forceRdy_),
        .to_err      (toErr),
        .to_owner    (toOwner)
    );
`else
    assign forceRdy_ = 1'b1;
    assign toErr     = 1'b0;
    assign toOwner   = BUS_OWNER_M0;
`endif

endmodule
